// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the button event decoder.
package btn_event_pkg;

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      PRESSED        = 3'd1,
      LONG_HELD      = 3'd2,
      WAIT_SECOND    = 3'd3,
      SECOND_PRESSED = 3'd4
   } state_t;

   localparam int DEF_CNT_W        = 12;
   localparam int DEF_LONG_TICKS   = 1000;
   localparam int DEF_DCLICK_TICKS = 250;

endpackage

// File: rtl/btn_event_decoder_if.sv
// Button level/timebase inputs and classified event outputs of the decoder.
interface btn_event_decoder_if;

   logic debounced_sig;
   logic tick;
   logic short_press;
   logic long_press;
   logic double_click;
   logic long_held;

   modport master (
      output debounced_sig, tick,
      input  short_press, long_press, double_click, long_held
   );

   modport slave (
      input  debounced_sig, tick,
      output short_press, long_press, double_click, long_held
   );

endinterface

// File: rtl/btn_edge_detect.sv
// Registers the debounced level and flags its rising and falling edges.
module btn_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_prev;

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) sig_prev <= 1'b0;
      else     sig_prev <= sig;
   end

   // Clearing sig_prev in reset makes a level held high across reset release look like a rise.
   assign rise = sig & ~sig_prev;
   assign fall = ~sig & sig_prev;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced button activity into short/long/double-click pulses and a long-held level.
module btn_event_decoder
   import btn_event_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DCLICK_TICKS = DEF_DCLICK_TICKS
) (
   input logic                clk,
   input logic                rst,
   btn_event_decoder_if.slave bus
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             dclick_q, dclick_d;
   logic             rise, fall;

   btn_edge_detect u_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (bus.debounced_sig),
      .rise (rise),
      .fall (fall)
   );

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      short_d  = 1'b0;
      long_d   = 1'b0;
      dclick_d = 1'b0;

      // Edges are tested before ticks so a coincident edge wins over a threshold tick.
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d = WAIT_SECOND;
               cnt_d   = '0;
            end else if (bus.tick) begin
               if (cnt_q == LONG_LAST) begin
                  state_d = LONG_HELD;
                  cnt_d   = '0;
                  long_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         LONG_HELD: begin
            if (fall) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         WAIT_SECOND: begin
            if (rise) begin
               state_d = SECOND_PRESSED;
               cnt_d   = '0;
            end else if (bus.tick) begin
               if (cnt_q == DCLICK_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  short_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         SECOND_PRESSED: begin
            if (fall) begin
               state_d  = IDLE;
               cnt_d    = '0;
               dclick_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         short_q  <= 1'b0;
         long_q   <= 1'b0;
         dclick_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         short_q  <= short_d;
         long_q   <= long_d;
         dclick_q <= dclick_d;
      end
   end

   assign bus.short_press  = short_q;
   assign bus.long_press   = long_q;
   assign bus.double_click = dclick_q;
   assign bus.long_held    = (state_q == LONG_HELD);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench: directed scenarios plus random traces, each compared against a trace-scanning model.
module tb_btn_event_decoder;

   localparam int LONG_T   = 4;
   localparam int DCLICK_T = 3;

   logic clk = 1'b0;
   logic rst;
   btn_event_decoder_if bus ();

   btn_event_decoder #(
      .CNT_W        (12),
      .LONG_TICKS   (LONG_T),
      .DCLICK_TICKS (DCLICK_T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-edge trace: inputs sampled at each posedge, outputs observed after it.
   // Output vector bits: [3]=short_press [2]=long_press [1]=double_click [0]=long_held.
   bit       s_q[$];
   bit       t_q[$];
   bit       r_q[$];
   bit [3:0] o_q[$];
   bit [3:0] e_q[$];

   task automatic step(input bit s, input bit t, input bit r);
      bus.debounced_sig = s;
      bus.tick          = t;
      rst               = r;
      @(posedge clk);
      s_q.push_back(s);
      t_q.push_back(t);
      r_q.push_back(r);
      @(negedge clk);
      o_q.push_back({bus.short_press, bus.long_press, bus.double_click, bus.long_held});
   endtask

   task automatic start_trace();
      s_q.delete();
      t_q.delete();
      r_q.delete();
      o_q.delete();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
   endtask

   // Holds the level for n ticks, one tick every second clock.
   task automatic hold_ticks(input bit s, input int n);
      for (int i = 0; i < n; i++) begin
         step(s, 1'b0, 1'b0);
         step(s, 1'b1, 1'b0);
      end
   endtask

   function automatic int cnt_bit(input int idx);
      int c = 0;
      for (int k = 0; k < o_q.size(); k++) begin
         bit [3:0] v = o_q[k];
         if (v[idx]) c++;
      end
      return c;
   endfunction

   // ---------------- reference model: scans the recorded trace for press/gap segments
   function automatic bit prev_lvl(input int k);
      return (k == 0 || r_q[k-1]) ? 1'b0 : s_q[k-1];
   endfunction

   function automatic bit rise_at(input int k);
      return !r_q[k] && s_q[k] && !prev_lvl(k);
   endfunction

   function automatic bit fall_at(input int k);
      return !r_q[k] && !s_q[k] && prev_lvl(k);
   endfunction

   function automatic int next_end(input int from);
      for (int k = from; k < s_q.size(); k++)
         if (r_q[k] || fall_at(k)) return k;
      return s_q.size();
   endfunction

   function automatic int next_rise(input int from);
      for (int k = from; k < s_q.size(); k++)
         if (r_q[k] || rise_at(k)) return k;
      return s_q.size();
   endfunction

   // Edge index of the cnt-th tick in [from, to), or -1 if there are fewer.
   function automatic int nth_tick(input int from, input int to, input int cnt);
      int seen = 0;
      for (int k = from; k < to; k++) begin
         if (t_q[k]) begin
            seen++;
            if (seen == cnt) return k;
         end
      end
      return -1;
   endfunction

   task automatic run_model();
      int n, k, b, c, d, lt, st;
      n = s_q.size();
      e_q.delete();
      for (int i = 0; i < n; i++) e_q.push_back(4'b0000);
      k = 0;
      while (k < n) begin
         if (!rise_at(k)) begin
            k++;
            continue;
         end
         // Press runs from the rise to the first fall or reset; ticks on those end edges do not count.
         b  = next_end(k + 1);
         lt = nth_tick(k + 1, b, LONG_T);
         if (lt >= 0) begin
            e_q[lt] = e_q[lt] | 4'b0100;
            for (int j = lt; j < b && j < n; j++) e_q[j] = e_q[j] | 4'b0001;
            k = b + 1;
            continue;
         end
         if (b >= n || r_q[b]) begin
            k = b + 1;
            continue;
         end
         c  = next_rise(b + 1);
         st = nth_tick(b + 1, c, DCLICK_T);
         if (st >= 0) begin
            e_q[st] = e_q[st] | 4'b1000;
            k = st + 1;
            continue;
         end
         if (c >= n || r_q[c]) begin
            k = c + 1;
            continue;
         end
         d = next_end(c + 1);
         if (d < n && !r_q[d]) e_q[d] = e_q[d] | 4'b0010;
         k = d + 1;
      end
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      start_trace();
      for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < o_q.size(); k++) begin
         if (r_q[k]) begin
            n_tests++;
            if (o_q[k] !== 4'b0000) begin
               n_fail++;
               $display("FAIL reset_outputs cycle %0d: got %b expected 0000", k, o_q[k]);
            end
         end
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL reset_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_short_press();
      int b;
      start_trace();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 2);
      b = s_q.size();
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (o_q[b+6] !== 4'b1000) begin
         n_fail++;
         $display("FAIL short_press_timing: got %b expected 1000 on 3rd gap tick", o_q[b+6]);
      end
      n_tests++;
      if (cnt_bit(3) !== 1 || cnt_bit(2) !== 0 || cnt_bit(1) !== 0) begin
         n_fail++;
         $display("FAIL short_press_counts: got s=%0d l=%0d d=%0d expected 1/0/0", cnt_bit(3), cnt_bit(2), cnt_bit(1));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL short_press_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_long_press();
      int a, b;
      start_trace();
      a = s_q.size();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 6);
      b = s_q.size();
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (o_q[a+8] !== 4'b0101) begin
         n_fail++;
         $display("FAIL long_press_timing: got %b expected 0101 on 4th tick", o_q[a+8]);
      end
      n_tests++;
      if (o_q[b-1] !== 4'b0001 || o_q[b] !== 4'b0000) begin
         n_fail++;
         $display("FAIL long_held_level: got %b then %b expected 0001 then 0000", o_q[b-1], o_q[b]);
      end
      n_tests++;
      if (cnt_bit(3) !== 0 || cnt_bit(2) !== 1 || cnt_bit(1) !== 0) begin
         n_fail++;
         $display("FAIL long_press_counts: got s=%0d l=%0d d=%0d expected 0/1/0", cnt_bit(3), cnt_bit(2), cnt_bit(1));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL long_press_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_double_click();
      int d;
      start_trace();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 1);
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 1);
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 1);
      d = s_q.size();
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (o_q[d] !== 4'b0010) begin
         n_fail++;
         $display("FAIL double_click_timing: got %b expected 0010 after second release", o_q[d]);
      end
      n_tests++;
      if (cnt_bit(3) !== 0 || cnt_bit(2) !== 0 || cnt_bit(1) !== 1) begin
         n_fail++;
         $display("FAIL double_click_counts: got s=%0d l=%0d d=%0d expected 0/0/1", cnt_bit(3), cnt_bit(2), cnt_bit(1));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL double_click_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_tie_long();
      int b;
      start_trace();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 3);
      step(1'b1, 1'b0, 1'b0);
      b = s_q.size();
      step(1'b0, 1'b1, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (cnt_bit(2) !== 0 || cnt_bit(0) !== 0) begin
         n_fail++;
         $display("FAIL tie_long_suppressed: got long=%0d held=%0d expected 0/0", cnt_bit(2), cnt_bit(0));
      end
      n_tests++;
      if (o_q[b+6] !== 4'b1000 || cnt_bit(3) !== 1) begin
         n_fail++;
         $display("FAIL tie_long_short: got %b count %0d expected 1000 count 1", o_q[b+6], cnt_bit(3));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL tie_long_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_tie_double();
      int d;
      start_trace();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 1);
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 2);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      hold_ticks(1'b1, 1);
      d = s_q.size();
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (o_q[d] !== 4'b0010 || cnt_bit(3) !== 0 || cnt_bit(1) !== 1) begin
         n_fail++;
         $display("FAIL tie_double: got %b s=%0d d=%0d expected 0010 s=0 d=1", o_q[d], cnt_bit(3), cnt_bit(1));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL tie_double_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int rs, a;
      start_trace();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 1);
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 1);
      rs = s_q.size();
      step(1'b0, 1'b1, 1'b1);
      hold_ticks(1'b0, 5);
      step(1'b1, 1'b0, 1'b1);
      a = s_q.size();
      step(1'b1, 1'b0, 1'b0);
      hold_ticks(1'b1, 5);
      step(1'b0, 1'b0, 1'b0);
      hold_ticks(1'b0, 4);
      n_tests++;
      if (o_q[rs] !== 4'b0000 || cnt_bit(3) !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_abort: got %b short=%0d expected 0000 short=0", o_q[rs], cnt_bit(3));
      end
      n_tests++;
      if (o_q[a+8] !== 4'b0101 || cnt_bit(2) !== 1) begin
         n_fail++;
         $display("FAIL mid_reset_new_press: got %b long=%0d expected 0101 long=1", o_q[a+8], cnt_bit(2));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL mid_reset_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_tick_high();
      int a;
      start_trace();
      step(1'b0, 1'b1, 1'b0);
      a = s_q.size();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (o_q[a+4] !== 4'b0101 || o_q[a+5] !== 4'b0000) begin
         n_fail++;
         $display("FAIL tick_high_long: got %b then %b expected 0101 then 0000", o_q[a+4], o_q[a+5]);
      end
      n_tests++;
      if (cnt_bit(3) !== 0 || cnt_bit(2) !== 1) begin
         n_fail++;
         $display("FAIL tick_high_counts: got s=%0d l=%0d expected 0/1", cnt_bit(3), cnt_bit(2));
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         n_tests++;
         if (o_q[k] !== e_q[k]) begin
            n_fail++;
            $display("FAIL tick_high_model cycle %0d: got %b expected %b", k, o_q[k], e_q[k]);
         end
      end
   endtask

   task automatic test_random();
      bit lvl = 1'b0;
      bit tick_all;
      int len;
      start_trace();
      while (s_q.size() < 800) begin
         tick_all = ((s_q.size() / 200) % 2) == 1;
         lvl      = ~lvl;
         len      = $urandom_range(1, 12);
         for (int i = 0; i < len; i++)
            step(lvl, tick_all ? 1'b1 : 1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0);
      end
      run_model();
      for (int k = 0; k < o_q.size(); k++) begin
         bit [3:0] v = o_q[k];
         n_tests++;
         if (v !== e_q[k]) begin
            n_fail++;
            $display("FAIL random_model cycle %0d: got %b expected %b", k, v, e_q[k]);
         end
         n_tests++;
         if ($countones(v[3:1]) > 1) begin
            n_fail++;
            $display("FAIL random_exclusive cycle %0d: got pulses %b expected at most one", k, v[3:1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_short_press();
      test_long_press();
      test_double_click();
      test_tie_long();
      test_tie_double();
      test_mid_reset();
      test_tick_high();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
